pipeline_controller: RTL and testbench
======================================

# pipeline_controller

Central sequencing block for the 5-stage ARM pipeline (IF, ID, EXE, MEM, WB). It generates the load enable for every pipeline register, including the PC, and the bubble/flush controls for the IF/ID and ID/EXE registers. It resolves load-use and RAW hazards, branch flushes and multi-cycle data-memory stalls, and keeps a saturating stall-cycle counter for performance analysis.

## Interface
Parameters:
- REG_W, 4, register-address width
- TIMEOUT, 255, maximum MEM_WAIT cycles before abort
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- id_src1, id_src2  in  REG_W  ID-stage source registers
- id_use_src1, id_use_src2  in  1  the ID instruction actually reads that source
- exe_dest  in  REG_W  EXE-stage destination register
- exe_wb_en, exe_mem_read  in  1  EXE writes back / EXE is a load
- mem_dest  in  REG_W  MEM-stage destination register
- mem_wb_en  in  1  MEM writes back
- forward_en  in  1  forwarding unit active
- branch_taken  in  1  EXE resolved a taken branch
- mem_req  in  1  MEM stage performs a data access this cycle
- mem_ready  in  1  data memory completes the access
- pc_ld, if_id_ld, id_exe_ld, exe_mem_ld, mem_wb_ld  out  1  register load enables
- if_id_flush, id_exe_flush  out  1  synchronous clear/bubble for that register
- hazard  out  1  load-use/RAW stall active this cycle
- mem_busy  out  1  controller is in MEM_WAIT
- mem_fault  out  1  one-cycle pulse on a timeout abort
- stall_cnt  out  CNT_W  saturating count of cycles with pc_ld=0

## Operation
- States are HOLD, RUN and MEM_WAIT. The state register updates on the rising clk edge.
- Control outputs are combinational from the state and the inputs. The pipeline registers sample them on the falling edge, so the outputs must settle within the first half-cycle.
- **rst asserted:** state=HOLD, stall_cnt=0, wait counter=0. While in reset, all ld=0, both flush=1, hazard=0, mem_busy=0, mem_fault=0.
- **HOLD:** outputs are the same as in reset. The controller moves unconditionally to RUN on the next edge.
- **Hazard term:** src1 hazard = id_use_src1 AND (a match in EXE OR a match in MEM). src2 hazard is formed the same way.
  - forward_en=0: an EXE match is exe_wb_en AND exe_dest==src. A MEM match is mem_wb_en AND mem_dest==src.
  - forward_en=1: only exe_mem_read AND exe_wb_en AND exe_dest==src counts.
- **RUN priority (highest first):**
  1. mem_req AND NOT mem_ready: all ld=0, no flush, next state=MEM_WAIT.
  2. branch_taken: all ld=1, if_id_flush=1, id_exe_flush=1, hazard=0.
  3. hazard: pc_ld=0, if_id_ld=0, id_exe_flush=1. All other ld=1.
  4. Otherwise: all ld=1, no flush.
- **MEM_WAIT:** mem_busy=1, all ld=0, no flush. branch_taken and hazard are ignored; the frozen EXE stage re-presents them after the stall.
  - Each cycle the wait counter increments.
  - mem_ready=1: behave exactly as RUN with condition 1 removed, and next state=RUN.
  - Counter reaches TIMEOUT with mem_ready=0: mem_fault=1, exe_mem_ld=1, mem_wb_ld=1, and mem_wb receives a bubble (the team's WB enable is gated by mem_fault). Next state=RUN.
  - The wait counter clears on every exit from MEM_WAIT.
- **stall_cnt:** increments on every cycle in which pc_ld=0 and the state is not HOLD. It saturates at all-ones.
- rst asserted mid-MEM_WAIT goes immediately to reset values. No fault pulse is generated.

## Timing
- A stall or flush decision takes effect on the falling edge of the same cycle. There is no added latency.
- A load-use hazard costs one bubble cycle. Example: LDR R1 followed by ADD R2,R1 gives one cycle with pc_ld=0.
- A branch costs two flushed instructions.
- A memory access costs N extra cycles when mem_ready rises N cycles after mem_req. mem_busy is high for those N cycles.
- A timeout abort takes exactly TIMEOUT cycles in MEM_WAIT before mem_fault.
- mem_req together with mem_ready in the same RUN cycle costs zero stall.

## Structure
- A shared package pipe_ctrl_pkg holds the state encoding (HOLD, RUN, MEM_WAIT) and the per-stage control bundle layout.
- One sub-module, hazard_detect, implements the purely combinational hazard term.
- The FSM, wait counter and stall counter stay in pipeline_controller.

## Test plan
- **Reset release:** assert rst mid-cycle, release it. Expect all ld=0 and both flush=1 asynchronously, then one HOLD cycle, then RUN with all ld=1 and stall_cnt=0.
- **Load-use stall:** exe_dest=1, exe_mem_read=1, exe_wb_en=1, forward_en=1, id_src1=1, id_use_src1=1. Expect hazard=1, pc_ld=0, if_id_ld=0, id_exe_flush=1 for one cycle, and stall_cnt=1.
- **Branch beats hazard:** apply the load-use setup plus branch_taken=1. Expect hazard=0, both flush=1, all ld=1.
- **Memory stall:** raise mem_req, then raise mem_ready 3 cycles later. Expect mem_busy=1 for 3 cycles, all ld=0 during them, stall_cnt+=3, then RUN. Asserting branch_taken during the wait must cause no flush.
- **Timeout:** TIMEOUT=4 with mem_ready held at 0. Expect the mem_fault pulse after 4 wait cycles, a return to RUN, and the wait counter cleared.
- **Saturation and async reset:** with CNT_W=2, force 5 stall cycles. Expect stall_cnt=3. Assert rst during MEM_WAIT and expect immediate reset values with no mem_fault.

Source files
------------

// File: rtl/pipeline_controller_pkg.sv
// Shared types for the 5-stage pipeline controller: FSM state encoding and
// the per-stage load/flush control bundle.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_HOLD     = 2'd0,
      ST_RUN      = 2'd1,
      ST_MEM_WAIT = 2'd2
   } state_t;

   typedef struct packed {
      logic pc_ld;
      logic if_id_ld;
      logic id_exe_ld;
      logic exe_mem_ld;
      logic mem_wb_ld;
      logic if_id_flush;
      logic id_exe_flush;
   } ctrl_t;

   localparam ctrl_t CTRL_HOLD   = ctrl_t'(7'b00000_11);
   localparam ctrl_t CTRL_RUN    = ctrl_t'(7'b11111_00);
   localparam ctrl_t CTRL_STALL  = ctrl_t'(7'b00000_00);
   localparam ctrl_t CTRL_HAZARD = ctrl_t'(7'b00111_01);
   localparam ctrl_t CTRL_BRANCH = ctrl_t'(7'b11111_11);
   // Abort drains EXE into MEM and a bubble into WB; front end stays frozen.
   localparam ctrl_t CTRL_ABORT  = ctrl_t'(7'b00011_00);

   function automatic ctrl_t run_ctrl(input logic branch, input logic hazard);
      if (branch) return CTRL_BRANCH;
      if (hazard) return CTRL_HAZARD;
      return CTRL_RUN;
   endfunction

endpackage

// File: rtl/pipeline_controller_if.sv
// Pipeline status inputs and control outputs of the pipeline controller.
// master = controller side, slave = datapath side.
interface pipeline_controller_if #(
   parameter int REG_W = 4,
   parameter int CNT_W = 16
);
   logic [REG_W-1:0] id_src1;
   logic [REG_W-1:0] id_src2;
   logic             id_use_src1;
   logic             id_use_src2;
   logic [REG_W-1:0] exe_dest;
   logic             exe_wb_en;
   logic             exe_mem_read;
   logic [REG_W-1:0] mem_dest;
   logic             mem_wb_en;
   logic             forward_en;
   logic             branch_taken;
   logic             mem_req;
   logic             mem_ready;

   logic             pc_ld;
   logic             if_id_ld;
   logic             id_exe_ld;
   logic             exe_mem_ld;
   logic             mem_wb_ld;
   logic             if_id_flush;
   logic             id_exe_flush;
   logic             hazard;
   logic             mem_busy;
   logic             mem_fault;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      input  id_src1, id_src2, id_use_src1, id_use_src2, exe_dest, exe_wb_en,
             exe_mem_read, mem_dest, mem_wb_en, forward_en, branch_taken,
             mem_req, mem_ready,
      output pc_ld, if_id_ld, id_exe_ld, exe_mem_ld, mem_wb_ld, if_id_flush,
             id_exe_flush, hazard, mem_busy, mem_fault, stall_cnt
   );

   modport slave (
      output id_src1, id_src2, id_use_src1, id_use_src2, exe_dest, exe_wb_en,
             exe_mem_read, mem_dest, mem_wb_en, forward_en, branch_taken,
             mem_req, mem_ready,
      input  pc_ld, if_id_ld, id_exe_ld, exe_mem_ld, mem_wb_ld, if_id_flush,
             id_exe_flush, hazard, mem_busy, mem_fault, stall_cnt
   );
endinterface

// File: rtl/pipeline_controller_hazard_detect.sv
// Combinational load-use / RAW hazard term for the ID-stage sources.
module hazard_detect #(
   parameter int REG_W = 4
) (
   input  logic [REG_W-1:0] i_src1,
   input  logic [REG_W-1:0] i_src2,
   input  logic             i_use_src1,
   input  logic             i_use_src2,
   input  logic [REG_W-1:0] i_exe_dest,
   input  logic             i_exe_wb_en,
   input  logic             i_exe_mem_read,
   input  logic [REG_W-1:0] i_mem_dest,
   input  logic             i_mem_wb_en,
   input  logic             i_forward_en,
   output logic             o_hazard
);
   logic w_exe_gate;
   logic w_mem_gate;
   logic w_hit1;
   logic w_hit2;

   // With forwarding only a load in EXE cannot be bypassed in time.
   assign w_exe_gate = i_exe_wb_en & (~i_forward_en | i_exe_mem_read);
   assign w_mem_gate = i_mem_wb_en & ~i_forward_en;

   assign w_hit1 = (w_exe_gate && (i_exe_dest == i_src1)) ||
                   (w_mem_gate && (i_mem_dest == i_src1));
   assign w_hit2 = (w_exe_gate && (i_exe_dest == i_src2)) ||
                   (w_mem_gate && (i_mem_dest == i_src2));

   assign o_hazard = (i_use_src1 & w_hit1) | (i_use_src2 & w_hit2);
endmodule

// File: rtl/pipeline_controller.sv
// Pipeline sequencing: load enables, bubbles/flushes, memory-wait handling
// with timeout abort, and a saturating stall-cycle counter.
//
// state    | meaning
// HOLD     | post-reset cycle, pipeline frozen and flushed
// RUN      | normal issue; hazards and branches resolved combinationally
// MEM_WAIT | data memory busy; whole pipeline frozen until ready or timeout
module pipeline_controller
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_W   = 4,
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 16
) (
   input logic clk,
   input logic rst,
   pipeline_controller_if.master pipe
);
   localparam int WAIT_W = $clog2(TIMEOUT + 1);

   state_t            r_state;
   logic [WAIT_W-1:0] r_wait_cnt;
   logic [CNT_W-1:0]  r_stall_cnt;

   state_t w_next;
   ctrl_t  w_ctrl;
   logic   w_hz_raw;
   logic   w_hazard;
   logic   w_busy;
   logic   w_fault;
   logic   w_timeout;

   hazard_detect #(.REG_W(REG_W)) u_hazard (
      .i_src1         (pipe.id_src1),
      .i_src2         (pipe.id_src2),
      .i_use_src1     (pipe.id_use_src1),
      .i_use_src2     (pipe.id_use_src2),
      .i_exe_dest     (pipe.exe_dest),
      .i_exe_wb_en    (pipe.exe_wb_en),
      .i_exe_mem_read (pipe.exe_mem_read),
      .i_mem_dest     (pipe.mem_dest),
      .i_mem_wb_en    (pipe.mem_wb_en),
      .i_forward_en   (pipe.forward_en),
      .o_hazard       (w_hz_raw)
   );

   assign w_timeout = (r_wait_cnt == WAIT_W'(TIMEOUT));

   always_comb begin
      w_ctrl   = CTRL_HOLD;
      w_hazard = 1'b0;
      w_busy   = 1'b0;
      w_fault  = 1'b0;
      w_next   = ST_RUN;
      case (r_state)
         ST_RUN: begin
            if (pipe.mem_req && !pipe.mem_ready) begin
               w_ctrl = CTRL_STALL;
               w_next = ST_MEM_WAIT;
            end else begin
               w_ctrl   = run_ctrl(pipe.branch_taken, w_hz_raw);
               w_hazard = w_hz_raw & ~pipe.branch_taken;
            end
         end
         ST_MEM_WAIT: begin
            w_busy = 1'b1;
            if (pipe.mem_ready) begin
               w_ctrl   = run_ctrl(pipe.branch_taken, w_hz_raw);
               w_hazard = w_hz_raw & ~pipe.branch_taken;
            end else if (w_timeout) begin
               w_ctrl  = CTRL_ABORT;
               w_fault = 1'b1;
            end else begin
               w_ctrl = CTRL_STALL;
               w_next = ST_MEM_WAIT;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_HOLD;
         r_wait_cnt  <= '0;
         r_stall_cnt <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == ST_MEM_WAIT && w_next == ST_MEM_WAIT)
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
         else
            r_wait_cnt <= '0;
         if (r_state != ST_HOLD && !w_ctrl.pc_ld && r_stall_cnt != '1)
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign pipe.pc_ld        = w_ctrl.pc_ld;
   assign pipe.if_id_ld     = w_ctrl.if_id_ld;
   assign pipe.id_exe_ld    = w_ctrl.id_exe_ld;
   assign pipe.exe_mem_ld   = w_ctrl.exe_mem_ld;
   assign pipe.mem_wb_ld    = w_ctrl.mem_wb_ld;
   assign pipe.if_id_flush  = w_ctrl.if_id_flush;
   assign pipe.id_exe_flush = w_ctrl.id_exe_flush;
   assign pipe.hazard       = w_hazard;
   assign pipe.mem_busy     = w_busy;
   assign pipe.mem_fault    = w_fault;
   assign pipe.stall_cnt    = r_stall_cnt;
endmodule

// File: tb/tb_pipeline_controller.sv
// Scoreboard bench for pipeline_controller: two instances (16-bit and 2-bit
// stall counters, TIMEOUT=4) driven with identical stimulus.
module tb_pipeline_controller;
   logic clk = 1'b0;
   logic rst;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   pipeline_controller_if #(.REG_W(4), .CNT_W(16)) u_if_a ();
   pipeline_controller_if #(.REG_W(4), .CNT_W(2))  u_if_b ();

   pipeline_controller #(.REG_W(4), .TIMEOUT(4), .CNT_W(16)) u_dut_a (
      .clk (clk), .rst (rst), .pipe (u_if_a.master));
   pipeline_controller #(.REG_W(4), .TIMEOUT(4), .CNT_W(2)) u_dut_b (
      .clk (clk), .rst (rst), .pipe (u_if_b.master));

   assign u_if_b.id_src1      = u_if_a.id_src1;
   assign u_if_b.id_src2      = u_if_a.id_src2;
   assign u_if_b.id_use_src1  = u_if_a.id_use_src1;
   assign u_if_b.id_use_src2  = u_if_a.id_use_src2;
   assign u_if_b.exe_dest     = u_if_a.exe_dest;
   assign u_if_b.exe_wb_en    = u_if_a.exe_wb_en;
   assign u_if_b.exe_mem_read = u_if_a.exe_mem_read;
   assign u_if_b.mem_dest     = u_if_a.mem_dest;
   assign u_if_b.mem_wb_en    = u_if_a.mem_wb_en;
   assign u_if_b.forward_en   = u_if_a.forward_en;
   assign u_if_b.branch_taken = u_if_a.branch_taken;
   assign u_if_b.mem_req      = u_if_a.mem_req;
   assign u_if_b.mem_ready    = u_if_a.mem_ready;

   // {pc, if_id, id_exe, exe_mem, mem_wb, if_id_flush, id_exe_flush}
   localparam logic [6:0] C_HOLD  = 7'b00000_11;
   localparam logic [6:0] C_RUN   = 7'b11111_00;
   localparam logic [6:0] C_STALL = 7'b00000_00;
   localparam logic [6:0] C_HAZ   = 7'b00111_01;
   localparam logic [6:0] C_BR    = 7'b11111_11;
   localparam logic [6:0] C_ABORT = 7'b00011_00;

   typedef struct {
      string       name;
      logic [9:0]  sig;
      logic [15:0] cnt;
      logic [1:0]  cnt_b;
   } exp_t;

   exp_t sb[$];

   function automatic exp_t mk(string n, logic [6:0] ctl, logic hz, logic busy,
                               logic flt, int cnt);
      exp_t e;
      e.name  = n;
      e.sig   = {ctl, hz, busy, flt};
      e.cnt   = 16'(cnt);
      e.cnt_b = (cnt > 3) ? 2'd3 : 2'(cnt);
      return e;
   endfunction

   function automatic logic [9:0] obs_a();
      return {u_if_a.pc_ld, u_if_a.if_id_ld, u_if_a.id_exe_ld, u_if_a.exe_mem_ld,
              u_if_a.mem_wb_ld, u_if_a.if_id_flush, u_if_a.id_exe_flush,
              u_if_a.hazard, u_if_a.mem_busy, u_if_a.mem_fault};
   endfunction

   task automatic set_idle();
      u_if_a.id_src1      = 4'd0;
      u_if_a.id_src2      = 4'd0;
      u_if_a.id_use_src1  = 1'b0;
      u_if_a.id_use_src2  = 1'b0;
      u_if_a.exe_dest     = 4'd0;
      u_if_a.exe_wb_en    = 1'b0;
      u_if_a.exe_mem_read = 1'b0;
      u_if_a.mem_dest     = 4'd0;
      u_if_a.mem_wb_en    = 1'b0;
      u_if_a.forward_en   = 1'b0;
      u_if_a.branch_taken = 1'b0;
      u_if_a.mem_req      = 1'b0;
      u_if_a.mem_ready    = 1'b0;
   endtask

   task automatic lu_setup();
      u_if_a.exe_dest     = 4'd1;
      u_if_a.exe_mem_read = 1'b1;
      u_if_a.exe_wb_en    = 1'b1;
      u_if_a.forward_en   = 1'b1;
      u_if_a.id_src1      = 4'd1;
      u_if_a.id_use_src1  = 1'b1;
   endtask

   task automatic do_reset();
      set_idle();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      exp_t e;
      for (int i = 0; i < 5; i++) begin
         case (i)
            0: begin rst = 1'b1; sb.push_back(mk("rst_asserted", C_HOLD, 0, 0, 0, 0)); @(negedge clk); end
            1: begin rst = 1'b0; sb.push_back(mk("hold_cycle", C_HOLD, 0, 0, 0, 0)); @(negedge clk); end
            2: begin sb.push_back(mk("first_run", C_RUN, 0, 0, 0, 0)); @(negedge clk); end
            3: begin #2 rst = 1'b1; sb.push_back(mk("async_rst_mid_cycle", C_HOLD, 0, 0, 0, 0)); #1; end
            default: begin rst = 1'b0; sb.push_back(mk("hold_after_rerelease", C_HOLD, 0, 0, 0, 0)); @(negedge clk); end
         endcase
         e = sb.pop_front();
         n_chk++;
         if (obs_a() !== e.sig) begin n_fail++; $display("FAIL %s: ld/flush/hz/busy/fault got %b expected %b", e.name, obs_a(), e.sig); end
         n_chk++;
         if (u_if_a.stall_cnt !== e.cnt) begin n_fail++; $display("FAIL %s stall_cnt: got %0d expected %0d", e.name, u_if_a.stall_cnt, e.cnt); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_load_use();
      exp_t e;
      do_reset();
      for (int i = 0; i < 9; i++) begin
         set_idle();
         case (i)
            0: begin lu_setup(); sb.push_back(mk("load_use_src1", C_HAZ, 1, 0, 0, 0)); end
            1: sb.push_back(mk("bubble_passed", C_RUN, 0, 0, 0, 1));
            2: begin lu_setup(); u_if_a.id_use_src1 = 1'b0; u_if_a.id_src2 = 4'd1; u_if_a.id_use_src2 = 1'b1;
                  sb.push_back(mk("load_use_src2", C_HAZ, 1, 0, 0, 1)); end
            3: begin lu_setup(); u_if_a.id_use_src1 = 1'b0; u_if_a.id_src2 = 4'd1;
                  sb.push_back(mk("src_not_used", C_RUN, 0, 0, 0, 2)); end
            4: begin u_if_a.forward_en = 1'b1; u_if_a.exe_wb_en = 1'b1; u_if_a.exe_dest = 4'd3;
                  u_if_a.id_src1 = 4'd3; u_if_a.id_use_src1 = 1'b1;
                  sb.push_back(mk("alu_forwarded", C_RUN, 0, 0, 0, 2)); end
            5: begin u_if_a.exe_wb_en = 1'b1; u_if_a.exe_dest = 4'd3;
                  u_if_a.id_src1 = 4'd3; u_if_a.id_use_src1 = 1'b1;
                  sb.push_back(mk("raw_exe_no_fwd", C_HAZ, 1, 0, 0, 2)); end
            6: begin u_if_a.mem_wb_en = 1'b1; u_if_a.mem_dest = 4'd7;
                  u_if_a.id_src2 = 4'd7; u_if_a.id_use_src2 = 1'b1;
                  sb.push_back(mk("raw_mem_no_fwd", C_HAZ, 1, 0, 0, 3)); end
            7: begin u_if_a.forward_en = 1'b1; u_if_a.mem_wb_en = 1'b1; u_if_a.mem_dest = 4'd7;
                  u_if_a.id_src2 = 4'd7; u_if_a.id_use_src2 = 1'b1;
                  sb.push_back(mk("mem_forwarded", C_RUN, 0, 0, 0, 4)); end
            default: begin u_if_a.exe_wb_en = 1'b1; u_if_a.exe_dest = 4'd2;
                  u_if_a.id_src1 = 4'd3; u_if_a.id_use_src1 = 1'b1;
                  sb.push_back(mk("no_match", C_RUN, 0, 0, 0, 4)); end
         endcase
         @(negedge clk);
         e = sb.pop_front();
         n_chk++;
         if (obs_a() !== e.sig) begin n_fail++; $display("FAIL %s: ld/flush/hz/busy/fault got %b expected %b", e.name, obs_a(), e.sig); end
         n_chk++;
         if (u_if_a.stall_cnt !== e.cnt) begin n_fail++; $display("FAIL %s stall_cnt: got %0d expected %0d", e.name, u_if_a.stall_cnt, e.cnt); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_branch();
      exp_t e;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         set_idle();
         case (i)
            0: begin lu_setup(); u_if_a.branch_taken = 1'b1;
                  sb.push_back(mk("branch_over_hazard", C_BR, 0, 0, 0, 0)); end
            1: begin u_if_a.branch_taken = 1'b1; sb.push_back(mk("branch_alone", C_BR, 0, 0, 0, 0)); end
            2: begin u_if_a.branch_taken = 1'b1; u_if_a.mem_req = 1'b1; u_if_a.mem_ready = 1'b1;
                  sb.push_back(mk("branch_mem_ready", C_BR, 0, 0, 0, 0)); end
            3: begin lu_setup(); u_if_a.mem_req = 1'b1; u_if_a.mem_ready = 1'b1;
                  sb.push_back(mk("hazard_mem_ready", C_HAZ, 1, 0, 0, 0)); end
            4: begin u_if_a.mem_req = 1'b1; u_if_a.mem_ready = 1'b1;
                  sb.push_back(mk("mem_zero_stall", C_RUN, 0, 0, 0, 1)); end
            default: sb.push_back(mk("branch_idle", C_RUN, 0, 0, 0, 1));
         endcase
         @(negedge clk);
         e = sb.pop_front();
         n_chk++;
         if (obs_a() !== e.sig) begin n_fail++; $display("FAIL %s: ld/flush/hz/busy/fault got %b expected %b", e.name, obs_a(), e.sig); end
         n_chk++;
         if (u_if_a.stall_cnt !== e.cnt) begin n_fail++; $display("FAIL %s stall_cnt: got %0d expected %0d", e.name, u_if_a.stall_cnt, e.cnt); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_mem_stall();
      exp_t e;
      do_reset();
      for (int i = 0; i < 9; i++) begin
         set_idle();
         case (i)
            0: begin u_if_a.mem_req = 1'b1; sb.push_back(mk("mem_req_not_ready", C_STALL, 0, 0, 0, 0)); end
            1: begin u_if_a.mem_req = 1'b1; u_if_a.branch_taken = 1'b1;
                  sb.push_back(mk("wait_branch_ignored", C_STALL, 0, 1, 0, 1)); end
            2: begin u_if_a.mem_req = 1'b1; lu_setup();
                  sb.push_back(mk("wait_hazard_ignored", C_STALL, 0, 1, 0, 2)); end
            3: begin u_if_a.mem_req = 1'b1; u_if_a.mem_ready = 1'b1;
                  sb.push_back(mk("wait_ready", C_RUN, 0, 1, 0, 3)); end
            4: sb.push_back(mk("run_after_wait", C_RUN, 0, 0, 0, 3));
            5: begin u_if_a.mem_req = 1'b1; sb.push_back(mk("mem_req_again", C_STALL, 0, 0, 0, 3)); end
            6: begin u_if_a.mem_req = 1'b1; u_if_a.mem_ready = 1'b1; lu_setup();
                  sb.push_back(mk("ready_with_hazard", C_HAZ, 1, 1, 0, 4)); end
            7: begin u_if_a.mem_req = 1'b1; u_if_a.mem_ready = 1'b1; u_if_a.branch_taken = 1'b1;
                  sb.push_back(mk("branch_after_wait", C_BR, 0, 0, 0, 5)); end
            default: sb.push_back(mk("mem_idle", C_RUN, 0, 0, 0, 5));
         endcase
         @(negedge clk);
         e = sb.pop_front();
         n_chk++;
         if (obs_a() !== e.sig) begin n_fail++; $display("FAIL %s: ld/flush/hz/busy/fault got %b expected %b", e.name, obs_a(), e.sig); end
         n_chk++;
         if (u_if_a.stall_cnt !== e.cnt) begin n_fail++; $display("FAIL %s stall_cnt: got %0d expected %0d", e.name, u_if_a.stall_cnt, e.cnt); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_timeout();
      exp_t e;
      do_reset();
      for (int i = 0; i < 14; i++) begin
         set_idle();
         u_if_a.mem_req = 1'b1;
         if (i == 0 || i == 7)
            sb.push_back(mk("timeout_req", C_STALL, 0, 0, 0, (i == 0) ? 0 : 6));
         else if (i <= 4)
            sb.push_back(mk("timeout_wait", C_STALL, 0, 1, 0, i));
         else if (i == 5)
            sb.push_back(mk("timeout_abort", C_ABORT, 0, 1, 1, 5));
         else if (i == 6) begin
            u_if_a.mem_req = 1'b0;
            sb.push_back(mk("after_abort", C_RUN, 0, 0, 0, 6));
         end else if (i <= 11)
            sb.push_back(mk("wait_after_abort", C_STALL, 0, 1, 0, i - 1));
         else if (i == 12) begin
            u_if_a.mem_ready = 1'b1;
            sb.push_back(mk("ready_at_limit_counter_cleared", C_RUN, 0, 1, 0, 11));
         end else begin
            u_if_a.mem_req = 1'b0;
            sb.push_back(mk("timeout_idle", C_RUN, 0, 0, 0, 11));
         end
         @(negedge clk);
         e = sb.pop_front();
         n_chk++;
         if (obs_a() !== e.sig) begin n_fail++; $display("FAIL %s[%0d]: ld/flush/hz/busy/fault got %b expected %b", e.name, i, obs_a(), e.sig); end
         n_chk++;
         if (u_if_a.stall_cnt !== e.cnt) begin n_fail++; $display("FAIL %s[%0d] stall_cnt: got %0d expected %0d", e.name, i, u_if_a.stall_cnt, e.cnt); end
         n_chk++;
         if (u_if_b.stall_cnt !== e.cnt_b) begin n_fail++; $display("FAIL %s[%0d] stall_cnt_2b: got %0d expected %0d", e.name, i, u_if_b.stall_cnt, e.cnt_b); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         set_idle();
         case (i)
            0, 2: begin u_if_a.mem_req = 1'b1;
                  sb.push_back(mk("b2b_req", C_STALL, 0, 0, 0, i / 2)); end
            1, 3: begin u_if_a.mem_ready = 1'b1;
                  sb.push_back(mk("b2b_ready", C_RUN, 0, 1, 0, (i + 1) / 2)); end
            4: begin u_if_a.mem_req = 1'b1; u_if_a.mem_ready = 1'b1;
                  sb.push_back(mk("b2b_zero_stall", C_RUN, 0, 0, 0, 2)); end
            default: sb.push_back(mk("b2b_idle", C_RUN, 0, 0, 0, 2));
         endcase
         @(negedge clk);
         e = sb.pop_front();
         n_chk++;
         if (obs_a() !== e.sig) begin n_fail++; $display("FAIL %s[%0d]: ld/flush/hz/busy/fault got %b expected %b", e.name, i, obs_a(), e.sig); end
         n_chk++;
         if (u_if_a.stall_cnt !== e.cnt) begin n_fail++; $display("FAIL %s[%0d] stall_cnt: got %0d expected %0d", e.name, i, u_if_a.stall_cnt, e.cnt); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_saturation_async_reset();
      exp_t e;
      do_reset();
      for (int i = 0; i < 11; i++) begin
         set_idle();
         if (i <= 4) begin
            lu_setup();
            sb.push_back(mk("sat_hazard", C_HAZ, 1, 0, 0, i));
         end else if (i == 5)
            sb.push_back(mk("sat_reached", C_RUN, 0, 0, 0, 5));
         else if (i == 6) begin
            u_if_a.mem_req = 1'b1;
            sb.push_back(mk("sat_mem_req", C_STALL, 0, 0, 0, 5));
         end else if (i == 7) begin
            u_if_a.mem_req = 1'b1;
            sb.push_back(mk("sat_mem_wait", C_STALL, 0, 1, 0, 6));
         end else if (i == 8) begin
            u_if_a.mem_req = 1'b1;
            sb.push_back(mk("rst_in_mem_wait", C_HOLD, 0, 0, 0, 0));
         end else if (i == 9) begin
            rst = 1'b0;
            u_if_a.mem_req = 1'b1;
            sb.push_back(mk("hold_after_wait_rst", C_HOLD, 0, 0, 0, 0));
         end else
            sb.push_back(mk("run_after_wait_rst", C_RUN, 0, 0, 0, 0));
         if (i == 8) begin
            @(negedge clk); #2 rst = 1'b1; #1;
         end else
            @(negedge clk);
         e = sb.pop_front();
         n_chk++;
         if (obs_a() !== e.sig) begin n_fail++; $display("FAIL %s[%0d]: ld/flush/hz/busy/fault got %b expected %b", e.name, i, obs_a(), e.sig); end
         n_chk++;
         if (u_if_a.stall_cnt !== e.cnt) begin n_fail++; $display("FAIL %s[%0d] stall_cnt: got %0d expected %0d", e.name, i, u_if_a.stall_cnt, e.cnt); end
         n_chk++;
         if (u_if_b.stall_cnt !== e.cnt_b) begin n_fail++; $display("FAIL %s[%0d] stall_cnt_2b: got %0d expected %0d", e.name, i, u_if_b.stall_cnt, e.cnt_b); end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      set_idle();
      test_reset();
      test_load_use();
      test_branch();
      test_mem_stall();
      test_timeout();
      test_back_to_back();
      test_saturation_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
